keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives a 4x4 active-low matrix keypad: strobes one row at a time and samples the columns.
//  Debounces whole scan frames and emits one key_valid pulse with a 4-bit key_code per press.
//  key_held stays high while that key remains down.
//  Sits between the PYNQ-Z2 keypad pins and the code-entry FSM of numeric_code_detonator.
// PARAMETERS
//  ROW_DWELL        125_000  clk cycles each row is driven low (1 ms @125 MHz); legal range >= 4
//  DEBOUNCE_FRAMES  3        consecutive identical frames required to accept a press or a release; legal range 1..15
// PORTS
//  clk        in   1  system clock, 125 MHz
//  rst        in   1  asynchronous reset, active-low
//  row        out  4  row strobes, active-low, exactly one bit low at all times
//  col        in   4  column inputs, active-low, pulled up externally, asynchronous
//  key_valid  out  1  one-cycle pulse: newly accepted key press
//  key_code   out  4  {row_idx[1:0], col_idx[1:0]}; held stable until the next key_valid
//  key_held   out  1  high from the key_valid pulse until the release is accepted
// BEHAVIOUR
//  Reset values (rst low, async):
//   - outputs: row=4'b1110, key_valid=0, key_code=0, key_held=0
//   - internal: dwell counter=0, row_idx=0, state=SEARCH, frame counters cleared
//  Reset mid-operation aborts the scan and any pending debounce.
//  Input sync: col passes a 2-flop synchronizer; all logic uses only the synchronized col_s.
//  Scan timing:
//   - dwell counter counts 0..ROW_DWELL-1 per row.
//   - col_s is sampled on the cycle dwell==ROW_DWELL-1.
//   - On the next cycle, row_idx increments (wrapping 3->0) and row rotates left: 1110->1101->1011->0111->1110.
//   - Frame = 4 rows = 4*ROW_DWELL cycles.
//  Frame result, evaluated at the row-3 sample:
//   - NONE: no low column bits in any row.
//   - SINGLE(code): exactly one low bit in the whole frame; code={row_idx,col_idx}, col_idx = position of the low bit.
//   - MULTI: two or more low bits, anywhere in the frame.
//  FSM (state updates one cycle after the frame-end sample):
//   - SEARCH, holds a candidate code and cnt:
//     - SINGLE(c) with c==candidate and cnt>0: cnt++.
//     - SINGLE(c) otherwise: candidate=c, cnt=1.
//     - NONE or MULTI: cnt=0.
//     - When cnt reaches DEBOUNCE_FRAMES: key_valid=1 for exactly one cycle, key_code=candidate,
//       key_held=1, rel_cnt=0, go to HELD.
//   - HELD:
//     - SINGLE(key_code) resets rel_cnt=0.
//     - Any other result (NONE, MULTI, or a different SINGLE): rel_cnt++.
//     - When rel_cnt reaches DEBOUNCE_FRAMES: key_held=0, cnt=0, go to SEARCH.
//  Counter widths: cnt and rel_cnt are 4 bit, saturating at DEBOUNCE_FRAMES.
//  Latency: key_valid is high in the cycle after the row-3 sample of the DEBOUNCE_FRAMES-th matching frame.
//  Repeat: no auto-repeat; a held key gives exactly one pulse.
//  Key slide: going straight from one key to another needs release frames, then press frames
//   -> second pulse at least 2*DEBOUNCE_FRAMES frames after the slide.
//  Glitches: a glitch shorter than ROW_DWELL that misses the sample point is invisible by design.
//  Ghosting: MULTI never produces a pulse; the two-key rollover case is rejected.
// TESTING (ROW_DWELL=8, DEBOUNCE_FRAMES=3, frame=32 cycles)
//  1. Pull rst low at cycle 50 mid-scan.
//     -> row=1110, key_valid=0, key_held=0 immediately (no clock edge needed).
//     -> After release, row steps to 1101 at cycle 8.
//  2. Hold row2/col1 (col[1] low while row[2] is low) for 6 frames.
//     -> Exactly one key_valid, key_code=4'h9, key_held=1.
//     -> Pulse comes 1 cycle after the 3rd frame-end sample.
//  3. Toggle key 0x9 every 10 cycles for 2 frames, then hold it steady.
//     -> No pulse during bouncing; a single pulse after 3 steady frames.
//  4. Press 0x0 and 0xF together for 5 frames.
//     -> key_valid never asserts, key_held stays 0.
//  5. Hold 0x9 until key_held=1, then release.
//     -> key_held falls after 3 NONE frames.
//     -> A re-press of 0x9 yields a second pulse.
//  6. Slide from 0x9 to 0x5 with no empty frame.
//     -> key_held falls after 3 frames.
//     -> key_valid with key_code=4'h5 after 3 more frames.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Pin and key-event bundle for keypad_scanner.
// master = scanner side, slave = keypad pins and code-entry consumer side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output row,
    output key_valid,
    output key_code,
    output key_held,
    input  col
  );

  modport slave (
    input  row,
    input  key_valid,
    input  key_code,
    input  key_held,
    output col
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with whole-frame debounce.
// One key_valid pulse per accepted press; key_held stays high until the release is accepted.
module keypad_scanner #(
  parameter int ROW_DWELL       = 125_000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int            DW         = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
  localparam logic [3:0]    DEB_LIMIT  = 4'(DEBOUNCE_FRAMES);

  typedef enum logic {SEARCH, HELD} state_t;

  logic [3:0]    r_colMeta;
  logic [3:0]    r_colSync;
  logic [DW-1:0] r_dwellCnt;
  logic [1:0]    r_rowIdx;
  logic [3:0]    r_row;
  logic [1:0]    r_frameLow;
  logic [3:0]    r_frameCode;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [3:0]    r_relCnt;
  logic [3:0]    r_candidate;
  logic [3:0]    r_keyCode;
  logic          r_keyValid;
  logic          r_keyHeld;

  logic          w_sample;
  logic          w_frameEnd;
  logic [2:0]    w_rowLowCnt;
  logic [1:0]    w_rowCol;
  logic [2:0]    w_frameSum;
  logic [1:0]    w_frameLowNext;
  logic [3:0]    w_frameCodeNext;
  logic          w_frameSingle;

  state_t        w_stateNext;
  logic [3:0]    w_cntNext;
  logic [3:0]    w_relCntNext;
  logic [3:0]    w_candidateNext;
  logic [3:0]    w_keyCodeNext;
  logic          w_keyValidNext;
  logic          w_keyHeldNext;

  assign w_sample   = (r_dwellCnt == DWELL_LAST);
  assign w_frameEnd = w_sample && (r_rowIdx == 2'd3);

  // Low-bit count saturates at 2 so one register distinguishes NONE / SINGLE / MULTI.
  always_comb begin
    w_rowLowCnt = 3'd0;
    w_rowCol    = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!r_colSync[c]) begin
        w_rowLowCnt = w_rowLowCnt + 3'd1;
        w_rowCol    = 2'(c);
      end
    end
    w_frameSum      = {1'b0, ((r_rowIdx == 2'd0) ? 2'd0 : r_frameLow)} + w_rowLowCnt;
    w_frameLowNext  = (w_frameSum >= 3'd2) ? 2'd2 : w_frameSum[1:0];
    w_frameCodeNext = (w_rowLowCnt == 3'd1) ? {r_rowIdx, w_rowCol} : r_frameCode;
    w_frameSingle   = (w_frameLowNext == 2'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_colMeta   <= 4'hF;
      r_colSync   <= 4'hF;
      r_dwellCnt  <= '0;
      r_rowIdx    <= 2'd0;
      r_row       <= 4'b1110;
      r_frameLow  <= 2'd0;
      r_frameCode <= 4'd0;
    end else begin
      r_colMeta <= kp.col;
      r_colSync <= r_colMeta;
      if (w_sample) begin
        r_dwellCnt  <= '0;
        r_rowIdx    <= r_rowIdx + 2'd1;
        r_row       <= {r_row[2:0], r_row[3]};
        r_frameLow  <= w_frameLowNext;
        r_frameCode <= w_frameCodeNext;
      end else begin
        r_dwellCnt <= r_dwellCnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SEARCH;
      r_cnt       <= 4'd0;
      r_relCnt    <= 4'd0;
      r_candidate <= 4'd0;
      r_keyCode   <= 4'd0;
      r_keyValid  <= 1'b0;
      r_keyHeld   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_relCnt    <= w_relCntNext;
      r_candidate <= w_candidateNext;
      r_keyCode   <= w_keyCodeNext;
      r_keyValid  <= w_keyValidNext;
      r_keyHeld   <= w_keyHeldNext;
    end
  end

  // Press and release are both accepted only after DEBOUNCE_FRAMES qualifying frames.
  always_comb begin
    w_stateNext     = r_state;
    w_cntNext       = r_cnt;
    w_relCntNext    = r_relCnt;
    w_candidateNext = r_candidate;
    w_keyCodeNext   = r_keyCode;
    w_keyValidNext  = 1'b0;
    w_keyHeldNext   = r_keyHeld;
    if (w_frameEnd) begin
      case (r_state)
        SEARCH: begin
          if (w_frameSingle) begin
            if ((w_frameCodeNext == r_candidate) && (r_cnt != 4'd0)) begin
              if (r_cnt < DEB_LIMIT) w_cntNext = r_cnt + 4'd1;
            end else begin
              w_candidateNext = w_frameCodeNext;
              w_cntNext       = 4'd1;
            end
          end else begin
            w_cntNext = 4'd0;
          end
          if (w_cntNext == DEB_LIMIT) begin
            w_keyValidNext = 1'b1;
            w_keyCodeNext  = w_candidateNext;
            w_keyHeldNext  = 1'b1;
            w_relCntNext   = 4'd0;
            w_stateNext    = HELD;
          end
        end
        HELD: begin
          if (w_frameSingle && (w_frameCodeNext == r_keyCode)) begin
            w_relCntNext = 4'd0;
          end else if (r_relCnt < DEB_LIMIT) begin
            w_relCntNext = r_relCnt + 4'd1;
          end
          if (w_relCntNext == DEB_LIMIT) begin
            w_keyHeldNext = 1'b0;
            w_cntNext     = 4'd0;
            w_stateNext   = SEARCH;
          end
        end
        default: w_stateNext = SEARCH;
      endcase
    end
  end

  assign kp.row       = r_row;
  assign kp.key_valid = r_keyValid;
  assign kp.key_code  = r_keyCode;
  assign kp.key_held  = r_keyHeld;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a frame-level reference model.
// A modelled keypad matrix drives col from the DUT row strobes and the pressed-key set.
module tb_keypad_scanner;

  localparam int D     = 8;
  localparam int DF    = 3;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pressed = 16'h0;

  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .ROW_DWELL      (D),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp.master)
  );

  // The matrix pulls column c low when the strobed row holds a pressed key in that column.
  always_comb begin
    kp.col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kp.row[r] && pressed[r*4+c]) kp.col[c] = 1'b0;
  end

  int         nCompared   = 0;
  int         nMismatched = 0;

  int         mK;
  logic [3:0] mMeta, mSync;
  int         frameKeys[$];
  bit         mHeld;
  int         mCand, mRun, mRel;
  logic [3:0] expCode;
  bit         expValid;

  int         pulseCount;
  int         lastPulseK;
  logic [3:0] lastPulseCode;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (model cycle %0d)", tag, observed, expected, mK);
    end
  endtask

  task automatic modelReset();
    mK = 0;
    mMeta = 4'hF;
    mSync = 4'hF;
    frameKeys.delete();
    mHeld = 0;
    mCand = 0;
    mRun = 0;
    mRel = 0;
    expCode = 4'h0;
    expValid = 0;
  endtask

  // Frame result from the list of low (row,col) positions seen at the four sample points.
  task automatic modelFrameEnd();
    bit single;
    int code;
    single = (frameKeys.size() == 1);
    code   = single ? frameKeys[0] : -1;
    if (!mHeld) begin
      if (single) begin
        if (code == mCand && mRun > 0) mRun++;
        else begin
          mCand = code;
          mRun = 1;
        end
      end else mRun = 0;
      if (mRun == DF) begin
        expValid = 1;
        expCode  = 4'(mCand);
        mHeld    = 1;
        mRel     = 0;
      end
    end else begin
      if (single && code == int'(expCode)) mRel = 0;
      else mRel++;
      if (mRel == DF) begin
        mHeld = 0;
        mRun  = 0;
      end
    end
  endtask

  task automatic modelAdvance(input logic [15:0] keys);
    int         rIdx;
    logic [3:0] colNow;
    rIdx   = (mK / D) % 4;
    colNow = 4'hF;
    for (int c = 0; c < 4; c++) if (keys[rIdx*4+c]) colNow[c] = 1'b0;
    expValid = 0;
    if (mK % D == D - 1) begin
      for (int c = 0; c < 4; c++) if (!mSync[c]) frameKeys.push_back(rIdx * 4 + c);
      if (rIdx == 3) begin
        modelFrameEnd();
        frameKeys.delete();
      end
    end
    mSync = mMeta;
    mMeta = colNow;
    mK++;
  endtask

  // Called at a falling edge: compare, drive this cycle's keys, advance to the next falling edge.
  task automatic stepCycle(input logic [15:0] keys);
    logic [3:0] expRow;
    expRow = 4'hF;
    expRow[(mK / D) % 4] = 1'b0;
    checkOutput("row", 32'(kp.row), 32'(expRow));
    checkOutput("key_valid", 32'(kp.key_valid), 32'(expValid));
    checkOutput("key_held", 32'(kp.key_held), 32'(mHeld));
    checkOutput("key_code", 32'(kp.key_code), 32'(expCode));
    if (kp.key_valid === 1'b1) begin
      pulseCount++;
      lastPulseK    = mK;
      lastPulseCode = kp.key_code;
    end
    pressed = keys;
    modelAdvance(keys);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) stepCycle(keys);
  endtask

  // Reset lands mid low-phase so no clock edge can explain the outputs changing.
  task automatic doReset();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_row", 32'(kp.row), 32'h0000_000E);
    checkOutput("rst_valid", 32'(kp.key_valid), 32'h0);
    checkOutput("rst_held", 32'(kp.key_held), 32'h0);
    checkOutput("rst_code", 32'(kp.key_code), 32'h0);
    pressed = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    int         waited;
    int         startK;
    int         fallK;
    logic [15:0] keys;
    int         kind, len, per, k1, k2;

    modelReset();
    pulseCount = 0;
    lastPulseK = -1;
    lastPulseCode = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("init_row", 32'(kp.row), 32'h0000_000E);
    checkOutput("init_held", 32'(kp.key_held), 32'h0);
    rst = 1'b1;
    modelReset();

    $display("[TB] reset mid-scan");
    applyStimulus(16'h0000, 50);
    doReset();

    $display("[TB] hold key 0x9 for six frames");
    pulseCount = 0;
    applyStimulus(16'h0200, 8);
    checkOutput("row_step", 32'(kp.row), 32'h0000_000D);
    applyStimulus(16'h0200, 6 * FRAME - 8);
    checkOutput("hold_pulses", 32'(pulseCount), 32'd1);
    checkOutput("hold_code", 32'(lastPulseCode), 32'h9);
    checkOutput("hold_latency", 32'(lastPulseK), 32'(3 * FRAME));
    checkOutput("hold_held", 32'(kp.key_held), 32'h1);
    doReset();

    $display("[TB] bouncing key 0x9");
    pulseCount = 0;
    for (int i = 0; i < 2 * FRAME; i++) stepCycle(((i / 10) % 2 == 0) ? 16'h0200 : 16'h0000);
    checkOutput("bounce_quiet", 32'(pulseCount), 32'd0);
    applyStimulus(16'h0200, 5 * FRAME);
    checkOutput("bounce_pulses", 32'(pulseCount), 32'd1);
    checkOutput("bounce_code", 32'(lastPulseCode), 32'h9);
    applyStimulus(16'h0000, 4 * FRAME);
    checkOutput("bounce_release", 32'(kp.key_held), 32'h0);

    $display("[TB] ghosting keys 0x0 and 0xF");
    pulseCount = 0;
    applyStimulus(16'h8001, 5 * FRAME);
    checkOutput("multi_pulses", 32'(pulseCount), 32'd0);
    checkOutput("multi_held", 32'(kp.key_held), 32'h0);
    applyStimulus(16'h0000, FRAME);

    $display("[TB] press, release, re-press");
    waited = 0;
    while (kp.key_held !== 1'b1 && waited < 6 * FRAME) begin
      stepCycle(16'h0200);
      waited++;
    end
    checkOutput("press_held", 32'(kp.key_held), 32'h1);
    startK = mK;
    waited = 0;
    while (kp.key_held === 1'b1 && waited < 6 * FRAME) begin
      stepCycle(16'h0000);
      waited++;
    end
    checkOutput("release_held", 32'(kp.key_held), 32'h0);
    checkOutput("release_delay", 32'(mK - startK), 32'(3 * FRAME));
    pulseCount = 0;
    applyStimulus(16'h0200, 4 * FRAME);
    checkOutput("repress_pulses", 32'(pulseCount), 32'd1);
    checkOutput("repress_code", 32'(lastPulseCode), 32'h9);

    $display("[TB] slide 0x9 -> 0x5");
    pulseCount = 0;
    startK = mK;
    fallK = -1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (fallK < 0 && kp.key_held !== 1'b1) fallK = mK;
      stepCycle(16'h0020);
    end
    checkOutput("slide_fall", 32'(fallK - startK), 32'(3 * FRAME));
    checkOutput("slide_pulses", 32'(pulseCount), 32'd1);
    checkOutput("slide_code", 32'(lastPulseCode), 32'h5);
    checkOutput("slide_latency", 32'(lastPulseK - startK), 32'(6 * FRAME));
    applyStimulus(16'h0000, 4 * FRAME);

    $display("[TB] randomized key traffic");
    for (int seg = 0; seg < 30; seg++) begin
      kind = $urandom_range(0, 4);
      len  = $urandom_range(4, 4 * FRAME);
      k1   = $urandom_range(0, 15);
      k2   = (k1 + $urandom_range(1, 15)) % 16;
      case (kind)
        0:       keys = 16'h0000;
        3:       keys = (16'h0001 << k1) | (16'h0001 << k2);
        default: keys = 16'h0001 << k1;
      endcase
      if (kind == 1) begin
        per = $urandom_range(3, 12);
        for (int i = 0; i < len; i++) stepCycle(((i / per) % 2 == 0) ? keys : 16'h0000);
      end else begin
        applyStimulus(keys, len);
      end
    end
    applyStimulus(16'h0000, 4 * FRAME);
    checkOutput("final_held", 32'(kp.key_held), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
